// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point radix-2 FFT / IFFT core.
//
// Collects a frame of four complex samples over a valid/ready input stream,
// runs two registered butterfly stages, then emits the four bins serially
// over a valid/ready output stream. The mode is chosen per frame:
// forward (unscaled) or inverse (each component divided by 4).
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   input sample handshake
//   in_inv                mode for the frame, sampled with sample 0 only
//   in_re / in_im         signed DW-bit sample
//   out_valid / out_ready output bin handshake
//   out_re / out_im       signed OW-bit bin value
//   out_idx / out_last    bin index 0..3, last flag on bin 3
//
// Build option:
//   FFT4_ROUND_EN  inverse divide-by-4 rounds half away from zero instead of
//                  truncating toward zero. Forward mode is unaffected.

// Divide-by-4 lane for inverse mode; passes the value through in forward mode.
module fft4_scale #(
    parameter int W  = 10,
    parameter int OW = 10
) (
    input  logic                 inv,
    input  logic signed [W-1:0]  v,
    output logic signed [OW-1:0] y
);
    logic signed [W:0] ve;
    logic signed [W:0] q;
`ifdef FFT4_ROUND_EN
    logic signed [W:0] mag;
`endif

    always_comb begin
        // One extra bit so negating the most negative value cannot wrap.
        ve = {v[W-1], v};
`ifdef FFT4_ROUND_EN
        mag = ve[W] ? -ve : ve;
        q   = (mag + $signed((W+1)'(2))) >>> 2;
        if (ve[W]) q = -q;
`else
        // Bias negatives by 3 so the arithmetic shift truncates toward zero.
        q = ve[W] ? ((ve + $signed((W+1)'(3))) >>> 2) : (ve >>> 2);
`endif
        y = inv ? OW'(q) : OW'(v);
    end
endmodule

module fft4_stream #(
    parameter int DW = 8,
    parameter int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic [1:0]           out_idx,
    output logic                 out_last
);
    localparam int FW = DW + 2;

    typedef enum logic [1:0] {COLLECT, BFLY1, BFLY2, EMIT} state_t;
    state_t state, state_nx;

    logic [1:0]           cnt;
    logic                 inv;
    logic signed [DW-1:0] xr [4];
    logic signed [DW-1:0] xi [4];

    // Stage-1 butterfly results
    logic signed [DW:0] ar, ai, br, bi, cr, ci, dr, di;

    // Stage-2 full-precision results and their scaled versions
    logic signed [FW-1:0] fr [4];
    logic signed [FW-1:0] fi [4];
    logic signed [OW-1:0] sr [4];
    logic signed [OW-1:0] si [4];

    // Output bin buffer
    logic signed [OW-1:0] bre [4];
    logic signed [OW-1:0] bim [4];

    wire in_xfer   = in_valid && in_ready;
    wire out_xfer  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (in_xfer && cnt == 2'd3) state_nx = BFLY1;
            BFLY1:   state_nx = BFLY2;
            BFLY2:   state_nx = EMIT;
            EMIT:    if (out_xfer && out_last) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    // Output logic: input side only depends on state, never on out_ready.
    always_comb begin
        in_ready = (state == COLLECT);
    end

    // Stage 2: combine a/c and b/d; the +-j rotation swaps with the mode.
    always_comb begin
        fr[0] = FW'(ar) + FW'(cr);
        fi[0] = FW'(ai) + FW'(ci);
        fr[2] = FW'(ar) - FW'(cr);
        fi[2] = FW'(ai) - FW'(ci);
        if (!inv) begin
            fr[1] = FW'(br) + FW'(di);
            fi[1] = FW'(bi) - FW'(dr);
            fr[3] = FW'(br) - FW'(di);
            fi[3] = FW'(bi) + FW'(dr);
        end else begin
            fr[1] = FW'(br) - FW'(di);
            fi[1] = FW'(bi) + FW'(dr);
            fr[3] = FW'(br) + FW'(di);
            fi[3] = FW'(bi) - FW'(dr);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        fft4_scale #(.W(FW), .OW(OW)) u_re (.inv(inv), .v(fr[g]), .y(sr[g]));
        fft4_scale #(.W(FW), .OW(OW)) u_im (.inv(inv), .v(fi[g]), .y(si[g]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            inv       <= 1'b0;
            ar <= '0; ai <= '0; br <= '0; bi <= '0;
            cr <= '0; ci <= '0; dr <= '0; di <= '0;
            for (int i = 0; i < 4; i++) begin
                xr[i]  <= '0;
                xi[i]  <= '0;
                bre[i] <= '0;
                bim[i] <= '0;
            end
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        xr[cnt] <= in_re;
                        xi[cnt] <= in_im;
                        if (cnt == 2'd0) inv <= in_inv;
                        cnt <= cnt + 2'd1;   // wraps to 0 after sample 3
                    end
                end
                BFLY1: begin
                    ar <= (DW+1)'(xr[0]) + (DW+1)'(xr[2]);
                    ai <= (DW+1)'(xi[0]) + (DW+1)'(xi[2]);
                    br <= (DW+1)'(xr[0]) - (DW+1)'(xr[2]);
                    bi <= (DW+1)'(xi[0]) - (DW+1)'(xi[2]);
                    cr <= (DW+1)'(xr[1]) + (DW+1)'(xr[3]);
                    ci <= (DW+1)'(xi[1]) + (DW+1)'(xi[3]);
                    dr <= (DW+1)'(xr[1]) - (DW+1)'(xr[3]);
                    di <= (DW+1)'(xi[1]) - (DW+1)'(xi[3]);
                end
                BFLY2: begin
                    for (int i = 0; i < 4; i++) begin
                        bre[i] <= sr[i];
                        bim[i] <= si[i];
                    end
                end
                EMIT: begin
                    // First EMIT cycle loads bin 0 into the registered outputs,
                    // so out_valid rises three edges after the last input.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_re    <= bre[0];
                        out_im    <= bim[0];
                        out_idx   <= 2'd0;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_re    <= '0;
                            out_im    <= '0;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
                        end else begin
                            out_re    <= bre[out_idx + 2'd1];
                            out_im    <= bim[out_idx + 2'd1];
                            out_idx   <= out_idx + 2'd1;
                            out_last  <= (out_idx == 2'd2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft4_stream.sv
// Self-checking bench for fft4_stream: a reference DFT model fills an
// expected-bin queue as each frame is driven, and a monitor pops and compares
// on every output transfer. Latency, backpressure hold, mode latch, input gaps
// and mid-frame reset are also checked.
module tb_fft4_stream;
    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, in_inv;
    logic signed [DW-1:0] in_re, in_im;
    logic                 out_valid, out_ready;
    logic signed [OW-1:0] out_re, out_im;
    logic [1:0]           out_idx;
    logic                 out_last;

    always #5 clk = ~clk;

    fft4_stream #(.DW(DW), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last)
    );

    int n_run  = 0;
    int n_fail = 0;
    int n_rx   = 0;

    typedef struct { int re; int im; int idx; } bin_t;
    bin_t exp_q[$];
    bin_t rx_e;

    task automatic chk(input string tag, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int div4(input int v);
`ifdef FFT4_ROUND_EN
        int m;
        m = (v < 0) ? -v : v;
        m = (m + 2) / 4;
        return (v < 0) ? -m : m;
`else
        return v / 4;   // integer division truncates toward zero
`endif
    endfunction

    // Direct 4-point DFT; inverse swaps bins 1 and 3, then scales.
    function automatic void push_frame(input int r[4], input int i[4], input bit inv);
        int er[4], ei[4];
        er[0] = r[0] + r[1] + r[2] + r[3];
        ei[0] = i[0] + i[1] + i[2] + i[3];
        er[2] = r[0] - r[1] + r[2] - r[3];
        ei[2] = i[0] - i[1] + i[2] - i[3];
        er[1] = r[0] + i[1] - r[2] - i[3];
        ei[1] = i[0] - r[1] - i[2] + r[3];
        er[3] = r[0] - i[1] - r[2] + i[3];
        ei[3] = i[0] + r[1] - i[2] - r[3];
        if (inv) begin
            int tr, ti;
            tr = er[1]; ti = ei[1];
            er[1] = er[3]; ei[1] = ei[3];
            er[3] = tr; ei[3] = ti;
            for (int k = 0; k < 4; k++) begin
                er[k] = div4(er[k]);
                ei[k] = div4(ei[k]);
            end
        end
        for (int k = 0; k < 4; k++) exp_q.push_back('{er[k], ei[k], k});
    endfunction

    // Monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", 1, 0);
            end else begin
                rx_e = exp_q.pop_front();
                chk("bin_re", out_re, rx_e.re);
                chk("bin_im", out_im, rx_e.im);
                chk("bin_idx", out_idx, rx_e.idx);
                chk("bin_last", out_last, rx_e.idx == 3);
            end
            n_rx++;
        end
    end

    // Called and returns at 1ns after a rising edge.
    task automatic send(input int re, input int im, input bit inv);
        bit ok;
        int t = 0;
        in_valid = 1'b1;
        in_re = DW'(re);
        in_im = DW'(im);
        in_inv = inv;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 100);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int r[4], input int i[4], input bit inv0,
                              input bit invr, input int gap_at, input int gap_len);
        push_frame(r, i, inv0);
        for (int n = 0; n < 4; n++) begin
            if (n == gap_at) repeat (gap_len) begin @(posedge clk); #1; end
            send(r[n], i[n], (n == 0) ? inv0 : invr);
        end
    endtask

    task automatic wait_rx(input int target);
        int t = 0;
        while (n_rx < target && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rx_count", n_rx, target);
    endtask

    task automatic wait_out_valid();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base, hre, him;
        int r[4], i[4];
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0;
        in_re = '0; in_im = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Forward impulse with latency measurement.
        push_frame('{1,0,0,0}, '{0,0,0,0}, 1'b0);
        send(1, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        chk("latency", lat, 3);
        @(posedge clk); #1;
        wait_rx(4);

        send_frame('{0,1,0,0}, '{0,0,0,0}, 0, 0, -1, 0);
        send_frame('{127,127,127,127}, '{0,0,0,0}, 0, 0, -1, 0);
        send_frame('{-128,-128,-128,-128}, '{0,0,0,0}, 0, 0, -1, 0);
        wait_rx(16);

        // Inverse scaling boundaries.
        send_frame('{4,0,0,0}, '{0,0,0,0}, 1, 1, -1, 0);
        send_frame('{-3,0,0,0}, '{0,0,0,0}, 1, 1, -1, 0);
        send_frame('{2,0,0,0}, '{0,0,0,0}, 1, 1, -1, 0);
        send_frame('{-5,0,0,0}, '{-128,0,0,0}, 1, 1, -1, 0);
        wait_rx(32);

        // Mode latched on sample 0 only.
        send_frame('{4,8,-12,3}, '{-7,1,9,-2}, 1, 0, -1, 0);
        send_frame('{4,8,-12,3}, '{-7,1,9,-2}, 0, 1, -1, 0);
        wait_rx(40);

        // Input gap mid-frame must not change results.
        send_frame('{10,-20,30,-40}, '{5,6,-7,8}, 0, 0, 2, 3);
        send_frame('{10,-20,30,-40}, '{5,6,-7,8}, 1, 1, 1, 3);
        wait_rx(48);

        // Random frames in both modes.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 4; k++) begin
                r[k] = int'($urandom_range(255)) - 128;
                i[k] = int'($urandom_range(255)) - 128;
            end
            send_frame(r, i, f[0], 0, -1, 0);
        end
        wait_rx(72);

        // Backpressure: hold at idx 1 for 5 cycles.
        out_ready = 1'b0;
        send_frame('{1,2,3,4}, '{0,0,0,0}, 0, 0, -1, 0);
        wait_out_valid();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        hre = exp_q[0].re;
        him = exp_q[0].im;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_re", out_re, hre);
            chk("bp_im", out_im, him);
            chk("bp_idx", out_idx, 1);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_rx(76);

        // Reset during EMIT at idx 2.
        out_ready = 1'b0;
        send_frame('{1,0,0,0}, '{0,0,0,0}, 0, 0, -1, 0);
        wait_out_valid();
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pre_rst_idx", out_idx, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_idx", out_idx, 0);
        exp_q.delete();
        base = n_rx;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_frame('{1,0,0,0}, '{0,0,0,0}, 0, 0, -1, 0);
        wait_rx(base + 4);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
